// File: rtl/regfile_wb_scheduler.sv
// Write-port owner for the 31x64 integer register file: busy scoreboard with
// RAW/WAW issue stall and round-robin arbitration of the writeback sources.
module regfile_wb_scheduler #(
   parameter int XLEN    = 64,
   parameter int NUM_SRC = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    iss_valid,
   input  logic [4:0]              iss_rs1,
   input  logic [4:0]              iss_rs2,
   input  logic                    iss_rs1_en,
   input  logic                    iss_rs2_en,
   input  logic [4:0]              iss_rd,
   input  logic                    iss_rd_wen,
   output logic                    iss_ready,
   input  logic [NUM_SRC-1:0]      wb_valid,
   input  logic [NUM_SRC*5-1:0]    wb_addr,
   input  logic [NUM_SRC*XLEN-1:0] wb_data,
   output logic [NUM_SRC-1:0]      wb_ready,
   output logic                    rf_wen,
   output logic [4:0]              rf_waddr,
   output logic [XLEN-1:0]         rf_wdata,
   output logic                    wb_err
);

   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

   logic [31:0]        busy_q, busy_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               rf_wen_q, rf_wen_d;
   logic [4:0]         rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
   logic               wb_err_q, wb_err_d;

   logic               grant_found;
   logic [PTR_W-1:0]   grant_idx;
   logic [NUM_SRC-1:0] grant_oh;
   logic [4:0]         sel_addr;
   logic [XLEN-1:0]    sel_data;
   logic               issue_fire;

   // Bit 0 of the scoreboard is held at zero, so x0 never stalls.
   assign iss_ready = !(iss_rs1_en && busy_q[iss_rs1])
                   && !(iss_rs2_en && busy_q[iss_rs2])
                   && !(iss_rd_wen && busy_q[iss_rd]);
   assign issue_fire = iss_valid && iss_ready;

   // Two passes over fixed indices: first those at/after rr_ptr, then the wrapped ones.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!grant_found && wb_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(i);
         end else begin
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!grant_found && wb_valid[i] && (PTR_W'(i) < rr_ptr_q)) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(i);
         end else begin
         end
      end
   end

   always_comb begin
      grant_oh = '0;
      sel_addr = 5'd0;
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         grant_oh[i] = grant_found && (grant_idx == PTR_W'(i));
         if (grant_oh[i]) begin
            sel_addr = wb_addr[5*i +: 5];
            sel_data = wb_data[XLEN*i +: XLEN];
         end else begin
         end
      end
   end

   assign wb_ready = grant_oh;

   // Clear is applied before set so a same-edge set of the same register wins.
   always_comb begin
      busy_d     = busy_q;
      rr_ptr_d   = rr_ptr_q;
      rf_wen_d   = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      wb_err_d   = wb_err_q;

      if (rf_wen_q) begin
         busy_d[rf_waddr_q] = 1'b0;
      end else begin
      end

      if (issue_fire && iss_rd_wen && (iss_rd != 5'd0)) begin
         busy_d[iss_rd] = 1'b1;
      end else begin
      end
      busy_d[0] = 1'b0;

      if (grant_found) begin
         rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
         if ((sel_addr == 5'd0) || !busy_q[sel_addr]) begin
            wb_err_d = 1'b1;
         end else begin
         end
         // An x0 writeback consumes its grant but never reaches the register file.
         if (sel_addr != 5'd0) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
         end else begin
         end
      end else begin
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= 32'd0;
         rr_ptr_q   <= '0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= 5'd0;
         rf_wdata_q <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         rr_ptr_q   <= rr_ptr_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         wb_err_q   <= wb_err_d;
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign wb_err   = wb_err_q;

endmodule
